ahb_input_stage_dma: RTL

- Master-side input stage of the DMA bus matrix, one instance per master port.
- Registers the master's address phase when the target output stage has not granted it, raises a request toward the output arbiters, and stalls the master via HREADYOUTS until granted.
- Routes the output stage's data-phase ready/response back to the master.

---
 rtl/ahb_bm_pkg.sv | 42 ++++
 rtl/ahb_input_stage_dma_if.sv | 53 +++++
 rtl/ahb_input_hold_reg.sv | 54 +++++
 rtl/ahb_input_stage_dma.sv | 129 ++++++++++++
 4 files changed

// File: rtl/ahb_bm_pkg.sv
// Shared AHB bus-matrix definitions: transfer/burst/response encodings,
// the address-phase control bundle and the default-slave error FSM states.
package ahb_bm_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    BURST_SINGLE = 3'b000,
    BURST_INCR   = 3'b001,
    BURST_WRAP4  = 3'b010,
    BURST_INCR4  = 3'b011,
    BURST_WRAP8  = 3'b100,
    BURST_INCR8  = 3'b101,
    BURST_WRAP16 = 3'b110,
    BURST_INCR16 = 3'b111
  } hburst_e;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ERR_IDLE = 2'b00,
    ERR_1    = 2'b01,
    ERR_2    = 2'b10
  } err_state_e;

  // Address-phase control fields (address carried separately, it is parameterised)
  typedef struct packed {
    logic [1:0] trans;
    logic       write;
    logic [2:0] size;
    logic [2:0] burst;
    logic [3:0] prot;
    logic       lock;
  } ahb_ctrl_t;

endpackage

// File: rtl/ahb_input_stage_dma_if.sv
// Bus bundle around one input stage: master-side (S) address phase, the
// stage's I-side presentation to decode/output stages, and the output-stage
// feedback. dec_miss exists only with AHB_INPUT_STAGE_DEFAULT_SLAVE_EN.
interface ahb_input_stage_dma_if #(parameter int ADDR_WIDTH = 32);
  logic                  HSELS;
  logic [ADDR_WIDTH-1:0] HADDRS;
  logic [1:0]            HTRANSS;
  logic                  HWRITES;
  logic [2:0]            HSIZES;
  logic [2:0]            HBURSTS;
  logic [3:0]            HPROTS;
  logic                  HMASTLOCKS;
  logic                  HREADYS;
  logic                  HREADYOUTS;
  logic                  HRESPS;
  logic                  HSELI;
  logic [ADDR_WIDTH-1:0] HADDRI;
  logic [1:0]            HTRANSI;
  logic                  HWRITEI;
  logic [2:0]            HSIZEI;
  logic [2:0]            HBURSTI;
  logic [3:0]            HPROTI;
  logic                  HMASTLOCKI;
  logic                  trans_pend;
  logic                  active_dec;
  logic                  readyout_dec;
  logic                  resp_dec;
`ifdef AHB_INPUT_STAGE_DEFAULT_SLAVE_EN
  logic                  dec_miss;
`endif

  // Input-stage view
  modport slave (
    input  HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS,
           HREADYS, active_dec, readyout_dec, resp_dec,
`ifdef AHB_INPUT_STAGE_DEFAULT_SLAVE_EN
    input  dec_miss,
`endif
    output HREADYOUTS, HRESPS, HSELI, HADDRI, HTRANSI, HWRITEI, HSIZEI,
           HBURSTI, HPROTI, HMASTLOCKI, trans_pend
  );

  // Master / matrix-fabric view
  modport master (
    output HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS,
           HREADYS, active_dec, readyout_dec, resp_dec,
`ifdef AHB_INPUT_STAGE_DEFAULT_SLAVE_EN
    output dec_miss,
`endif
    input  HREADYOUTS, HRESPS, HSELI, HADDRI, HTRANSI, HWRITEI, HSIZEI,
           HBURSTI, HPROTI, HMASTLOCKI, trans_pend
  );
endinterface

// File: rtl/ahb_input_hold_reg.sv
// Address-phase holding register and presentation mux. While a transfer is
// pending the held copy is presented (SEQ rewritten to NONSEQ/INCR so a burst
// that lost arbitration restarts as undefined length); otherwise S-side is live.
module ahb_input_hold_reg
  import ahb_bm_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  load,
  input  logic                  pend,
  input  logic                  sel_s,
  input  logic [ADDR_WIDTH-1:0] addr_s,
  input  ahb_ctrl_t             ctrl_s,
  output logic                  sel_i,
  output logic [ADDR_WIDTH-1:0] addr_i,
  output ahb_ctrl_t             ctrl_i
);

  logic [ADDR_WIDTH-1:0] addr_q;
  ahb_ctrl_t             ctrl_q;
  ahb_ctrl_t             held;

  // Capture every accepted address phase, pending or not
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q <= '0;
      ctrl_q <= '0;
    end else if (load) begin
      addr_q <= addr_s;
      ctrl_q <= ctrl_s;
    end
  end

  // Select held (with SEQ override) or live address phase
  always_comb begin
    held = ctrl_q;
    if (ctrl_q.trans == TRANS_SEQ) begin
      held.trans = TRANS_NONSEQ;
      held.burst = BURST_INCR;
    end
    if (pend) begin
      sel_i  = 1'b1;
      addr_i = addr_q;
      ctrl_i = held;
    end else begin
      sel_i  = sel_s;
      addr_i = addr_s;
      ctrl_i = ctrl_s;
    end
  end

endmodule

// File: rtl/ahb_input_stage_dma.sv
// Master-side input stage of the DMA bus matrix. Holds an ungranted address
// phase, requests the output arbiters, stalls the master until granted and
// routes the owning output stage's ready/response back.
// Optional: AHB_INPUT_STAGE_DEFAULT_SLAVE_EN adds dec_miss and a two-cycle
// ERROR response generated locally for unmapped accesses.
module ahb_input_stage_dma
  import ahb_bm_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input logic                  HCLK,
  input logic                  HRESETn,
  ahb_input_stage_dma_if.slave bus
);

  logic                  addr_ph;
  logic                  new_tran;
  logic                  req_tran;
  logic                  trans_pend_w;
  logic                  pend_reg;
  logic                  data_phase_reg;
  logic                  ready_out;
  logic                  resp_out;
  ahb_ctrl_t             ctrl_s;
  ahb_ctrl_t             ctrl_i;
  logic                  sel_i;
  logic [ADDR_WIDTH-1:0] addr_i;

  // Gated by reset so nothing requests while the stage is held in reset
  assign addr_ph  = HRESETn & bus.HSELS & bus.HREADYS;
  assign new_tran = addr_ph & bus.HTRANSS[1];

`ifdef AHB_INPUT_STAGE_DEFAULT_SLAVE_EN
  err_state_e err_q, err_d;
  logic       miss_tran;

  assign miss_tran = new_tran & bus.dec_miss;
  assign req_tran  = new_tran & ~bus.dec_miss;

  // Error FSM state register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) err_q <= ERR_IDLE;
    else          err_q <= err_d;
  end

  // Error FSM next state: miss -> two-cycle ERROR, back-to-back allowed from ERR_2
  always_comb begin
    err_d = ERR_IDLE;
    case (err_q)
      ERR_IDLE: err_d = miss_tran ? ERR_1 : ERR_IDLE;
      ERR_1:    err_d = ERR_2;
      ERR_2:    err_d = miss_tran ? ERR_1 : ERR_IDLE;
      default:  err_d = ERR_IDLE;
    endcase
  end
`else
  assign req_tran = new_tran;
`endif

  assign trans_pend_w = pend_reg | req_tran;

  assign ctrl_s = '{trans: bus.HTRANSS, write: bus.HWRITES, size: bus.HSIZES,
                    burst: bus.HBURSTS, prot: bus.HPROTS, lock: bus.HMASTLOCKS};

  ahb_input_hold_reg #(.ADDR_WIDTH(ADDR_WIDTH)) u_hold (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .load    (addr_ph),
    .pend    (pend_reg),
    .sel_s   (bus.HSELS),
    .addr_s  (bus.HADDRS),
    .ctrl_s  (ctrl_s),
    .sel_i   (sel_i),
    .addr_i  (addr_i),
    .ctrl_i  (ctrl_i)
  );

  // Pending flag: set on an ungranted request, cleared once granted with ready
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)
      pend_reg <= 1'b0;
    else if (!pend_reg)
      pend_reg <= req_tran & ~bus.active_dec;
    else if (bus.active_dec & bus.readyout_dec)
      pend_reg <= 1'b0;
  end

  // Data-phase ownership advances only when the current data phase completes
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)
      data_phase_reg <= 1'b0;
    else if (bus.readyout_dec)
      data_phase_reg <= trans_pend_w & bus.active_dec;
  end

  // Ready/response back to the master
  always_comb begin
    ready_out = 1'b1;
    resp_out  = RESP_OKAY;
    if (data_phase_reg) begin
      ready_out = bus.readyout_dec;
      resp_out  = bus.resp_dec;
    end else if (pend_reg) begin
      ready_out = 1'b0;
    end
`ifdef AHB_INPUT_STAGE_DEFAULT_SLAVE_EN
    if (err_q == ERR_1) begin
      ready_out = 1'b0;
      resp_out  = RESP_ERROR;
    end else if (err_q == ERR_2) begin
      ready_out = 1'b1;
      resp_out  = RESP_ERROR;
    end
`endif
  end

  assign bus.HREADYOUTS = ready_out;
  assign bus.HRESPS     = resp_out;
  assign bus.trans_pend = trans_pend_w;
  assign bus.HSELI      = sel_i;
  assign bus.HADDRI     = addr_i;
  assign bus.HTRANSI    = HRESETn ? ctrl_i.trans : TRANS_IDLE;
  assign bus.HWRITEI    = ctrl_i.write;
  assign bus.HSIZEI     = ctrl_i.size;
  assign bus.HBURSTI    = ctrl_i.burst;
  assign bus.HPROTI     = ctrl_i.prot;
  assign bus.HMASTLOCKI = ctrl_i.lock;

endmodule
